// File: rtl/cordic_phase.sv
// Iterative CORDIC vectoring: one I/Q pair in, atan2(y,x) out as signed Q8.10 radians.
// Latency ITER+2 cycles from accept to out_valid; in_ready is low while busy, and samples offered then are dropped.
module cordic_phase #(
    parameter int IN_W = 16,
    parameter int ITER = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [IN_W-1:0] x_in,
    input  logic signed [IN_W-1:0] y_in,
    output logic                   out_valid,
    output logic signed [18:0]     phase_out
);

    localparam int W  = IN_W + 2;
    localparam int ZW = 23;
    localparam int CW = 4;

    localparam logic signed [ZW-1:0] PI_Z = 23'sd51472;
    localparam logic signed [ZW-1:0] SAT  = 23'sd3217;
    localparam logic [CW-1:0]        LAST = CW'(ITER - 1);

    typedef enum logic [1:0] {IDLE, PRE, ROT, DONE} state_t;

    state_t                state, state_nxt;
    logic signed [W-1:0]   x, y;
    logic signed [ZW-1:0]  z;
    logic [CW-1:0]         i;
    logic                  zero_in;
    logic signed [ZW-1:0]  z_rnd;
    logic signed [18:0]    phase_sat;

    // atan(2^-k) in Q14 radians
    function automatic logic signed [ZW-1:0] atan_rom(input logic [CW-1:0] k);
        case (k)
            4'd0:    atan_rom = 23'sd12868;
            4'd1:    atan_rom = 23'sd7596;
            4'd2:    atan_rom = 23'sd4014;
            4'd3:    atan_rom = 23'sd2037;
            4'd4:    atan_rom = 23'sd1023;
            4'd5:    atan_rom = 23'sd512;
            4'd6:    atan_rom = 23'sd256;
            4'd7:    atan_rom = 23'sd128;
            4'd8:    atan_rom = 23'sd64;
            4'd9:    atan_rom = 23'sd32;
            4'd10:   atan_rom = 23'sd16;
            4'd11:   atan_rom = 23'sd8;
            4'd12:   atan_rom = 23'sd4;
            4'd13:   atan_rom = 23'sd2;
            default: atan_rom = 23'sd0;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = PRE;
            PRE:  state_nxt = ROT;
            ROT:  if (i == LAST) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == IDLE);
    end

    // Q14 -> Q10 with round-half-up, then clamp to +/-pi
    assign z_rnd = (z + 23'sd8) >>> 4;

    always_comb begin
        if (z_rnd > SAT)       phase_sat = 19'sd3217;
        else if (z_rnd < -SAT) phase_sat = -19'sd3217;
        else                   phase_sat = z_rnd[18:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x         <= '0;
            y         <= '0;
            z         <= '0;
            i         <= '0;
            zero_in   <= 1'b0;
            out_valid <= 1'b0;
            phase_out <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x       <= {{2{x_in[IN_W-1]}}, x_in};
                        y       <= {{2{y_in[IN_W-1]}}, y_in};
                        z       <= '0;
                        i       <= '0;
                        zero_in <= (x_in == '0) && (y_in == '0);
                    end
                end
                PRE: begin
                    // fold the left half-plane onto the right; the two guard bits absorb -(-2^(IN_W-1))
                    if (x[W-1]) begin
                        x <= -x;
                        y <= -y;
                        z <= y[W-1] ? -PI_Z : PI_Z;
                    end else begin
                        z <= '0;
                    end
                    i <= '0;
                end
                ROT: begin
                    if (!y[W-1]) begin
                        x <= x + (y >>> i);
                        y <= y - (x >>> i);
                        z <= z + atan_rom(i);
                    end else begin
                        x <= x - (y >>> i);
                        y <= y + (x >>> i);
                        z <= z - atan_rom(i);
                    end
                    i <= i + CW'(1);
                end
                DONE: begin
                    // the origin would otherwise accumulate the full ATAN sum
                    phase_out <= zero_in ? 19'sd0 : phase_sat;
                    out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_phase.sv
// Scoreboarded bench for cordic_phase: atan2 reference model, latency, throughput and reset-abort checks.
module tb_cordic_phase;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [15:0] x_in = '0;
    logic signed [15:0] y_in = '0;
    logic               out_valid;
    logic signed [18:0] phase_out;

    cordic_phase #(.IN_W(16), .ITER(12)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x_in(x_in), .y_in(y_in), .out_valid(out_valid), .phase_out(phase_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int lo;
        int hi;
        int acc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   busy_run = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic int clamp(input int v);
        if (v > 3217)  return 3217;
        if (v < -3217) return -3217;
        return v;
    endfunction

    function automatic int round_rad(input real a);
        return clamp(int'($floor(a * 1024.0 + 0.5)));
    endfunction

    function automatic int ref_phase(input int x, input int y);
        if (x == 0 && y == 0) return 0;
        return round_rad($atan2(real'(y), real'(x)));
    endfunction

    // Monitor: pops one expectation per out_valid pulse
    always @(negedge clk) begin
        if (rst) begin
            busy_run = 0;
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 1, 0, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("phase_out", int'(phase_out), e.lo, e.hi);
                    check("latency", cyc - e.acc, 14, 14);
                    check("busy_cycles", busy_run, 14, 14);
                end
            end
            if (!in_ready) busy_run++;
            else           busy_run = 0;
        end
    end

    task automatic push_exp(input int r, input int acc);
        exp_t e;
        e.lo  = clamp(r - 2);
        e.hi  = clamp(r + 2);
        e.acc = acc;
        exp_q.push_back(e);
    endtask

    // Waits for in_ready, presents the sample for the accepting edge; in hold mode keeps in_valid high with junk data.
    task automatic send(input int x, input int y, input int r, input bit hold, output int acc);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) check("in_ready_timeout", 0, 1, 1);
        in_valid = 1'b1;
        x_in = 16'(x);
        y_in = 16'(y);
        push_exp(r, cyc + 1);
        @(posedge clk);
        #1;
        acc = cyc;
        if (hold) begin
            x_in = 16'($urandom);
            y_in = 16'($urandom);
        end else begin
            in_valid = 1'b0;
        end
    endtask

    task automatic send_ref(input int x, input int y);
        int acc;
        send(x, y, ref_phase(x, y), 1'b0, acc);
    endtask

    task automatic drain;
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0, 0);
    endtask

    initial begin
        int   acc, last_acc;
        int   x, y;
        real  th;
        longint m2;

        repeat (3) @(negedge clk);
        check("reset_out_valid", int'(out_valid), 0, 0);
        check("reset_phase_out", int'(phase_out), 0, 0);
        check("reset_in_ready", int'(in_ready), 1, 1);
        rst = 1'b0;

        // Directed corner cases
        send_ref(16384, 0);       drain();
        send_ref(0, 16384);       drain();
        send_ref(0, -16384);      drain();
        send_ref(-16384, 0);      drain();
        send_ref(-16384, -1);     drain();
        send_ref(-32768, -32768); drain();
        send_ref(0, 0);           drain();
        send_ref(32767, -32768);  drain();

        // Sweep with in_valid held high; junk data while busy must never be latched
        last_acc = 0;
        for (int k = 0; k < 100; k++) begin
            th = -3.14159265358979 + (real'(k) + 0.5) * 6.28318530717959 / 100.0;
            x = int'($floor(16384.0 * $cos(th) + 0.5));
            y = int'($floor(16384.0 * $sin(th) + 0.5));
            send(x, y, round_rad(th), 1'b1, acc);
            if (k > 0) check("accept_spacing", acc - last_acc, 15, 15);
            last_acc = acc;
        end
        @(negedge clk);
        in_valid = 1'b0;
        drain();

        // Random vectors with gaps
        for (int k = 0; k < 30; k++) begin
            do begin
                x = int'($urandom_range(65535)) - 32768;
                y = int'($urandom_range(65535)) - 32768;
                m2 = longint'(x) * x + longint'(y) * y;
            end while (m2 < 64'd67108864);
            send_ref(x, y);
            repeat ($urandom_range(3)) @(negedge clk);
        end
        drain();

        // Reset in the middle of a conversion aborts it
        send_ref(-20000, 9000);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("abort_in_ready", int'(in_ready), 1, 1);
        check("abort_out_valid", int'(out_valid), 0, 0);
        check("abort_phase_out", int'(phase_out), 0, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        send_ref(12000, 12000);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
